crc24_attach: RTL and testbench
===============================

Name: crc24_attach

Overview:
- Stage directly upstream of the turbo interleaver.
- Accepts a serial transport-block payload and computes the LTE CRC24A over it, MSB first.
- Emits payload followed by 24 parity bits as one contiguous K-bit serial block, K = 1056 (small) or 6144 (large).
- Drives the interleaver's CRC_start / CRC_blocksize / CRC_end control signals directly.

Parameters:
- K_SMALL, 1056, small code block length including CRC
- K_LARGE, 6144, large code block length including CRC
- CRC_LEN, 24, number of parity bits appended
- CRC_POLY, 24'h864CFB, generator low-order taps (x^24 implicit)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- tb_data_in  in  1  payload bit, consumed every cycle from accept through payload end
- tb_start  in  1  pulse with first payload bit; honoured only when in_ready=1
- tb_blocksize  in  1  0 = small, 1 = large; sampled with accepted tb_start
- in_ready  out  1  high when a new tb_start will be accepted
- data_out  out  1  registered serial output bit to interleaver
- out_valid  out  1  high for each of the K output bits
- CRC_start  out  1  one-cycle pulse coincident with first output bit
- CRC_blocksize  out  1  latched tb_blocksize, stable from CRC_start through CRC_end
- CRC_end  out  1  one-cycle pulse coincident with last (24th parity) output bit

Behaviour:
- Reset values (async, immediate): state=IDLE, counter=0, crc_reg=0, data_out=0, out_valid=0, CRC_start=0, CRC_end=0, CRC_blocksize=0, in_ready=1 (combinational from IDLE).
- P = K - 24 payload bits: 1032 small, 6120 large. Bit counter is 13 bits.
- States:
  - IDLE: in_ready=1. tb_start=1 captures bit0 and tb_blocksize, loads crc with bit0 shifted into the zero register, counter=1, then go to PAYLOAD. tb_start=0: stay.
  - PAYLOAD: consume tb_data_in each cycle and update crc (fb = crc[23]^bit; crc = {crc[22:0],0} ^ (fb ? CRC_POLY : 0)); counter++. On the cycle that consumes bit P-1, go to APPEND and reset counter to 0. tb_start is ignored here.
  - APPEND: shift crc_reg MSB out onto the output path, 24 cycles, counter 0..23. Go to IDLE after counter=23.
- Latency and timing:
  - Output register gives 1-cycle latency. If accept is at cycle t: CRC_start and bit0 at t+1, payload on t+1..t+P, parity on t+P+1..t+P+24, CRC_end at t+P+24.
  - out_valid is continuous, with no gaps, over all K bits.
- Back-to-back: the FSM is in IDLE in cycle t+P+24, so a tb_start there is accepted. Its CRC_start lands at t+P+25, immediately after the previous CRC_end, with zero gap.
- No CRC inversion or reflection; initial value 0. CRC_blocksize updates only on accepted tb_start.
- Reset mid-block aborts it: outputs drop per reset values, and no CRC_end is issued for the partial block.
- tb_data_in is don't-care outside IDLE-accept and PAYLOAD cycles.

Decomposition:
- Shared package crc_pkg: K_SMALL, K_LARGE, CRC_LEN, CRC_POLY, payload-length constants, and a 2-bit state encoding (IDLE, PAYLOAD, APPEND).
- One sub-module: crc24_lfsr. Inputs: clk, reset, clear, shift_in_en, bit_in, shift_out_en. Output: crc_msb. It is the serial Galois LFSR; a zero is inserted on shift-out.
- The FSM, counter and output registers stay in crc24_attach.

Test Plan:
- Small, all-zero payload: tb_start at t with tb_blocksize=0 → CRC_start at t+1, 1056 zero bits, 24 zero parity, CRC_end at t+1056, CRC_blocksize=0 throughout.
- Small, payload zero except bit 1031 = 1 → parity bits equal 24'h864CFB MSB first (1000_0110_0100_1100_1111_1011), CRC_end at t+1056.
- Large, random payload → exactly 6144 out_valid cycles. The serial CRC24A of the full output block (payload+parity) must be 0; CRC_end at t+6144.
- Back-to-back: second tb_start held in the cycle CRC_end is high → accepted; next CRC_start on the following cycle; out_valid never drops. A tb_start during PAYLOAD is ignored.
- Reset asserted at payload bit 500 → outputs zero asynchronously, in_ready=1. A new small block then completes with correct CRC and no stale CRC_end.
- tb_blocksize toggled mid-block → CRC_blocksize unchanged until next accepted tb_start.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared constants, state encoding and the CRC24A serial update step for the
// transport-block CRC attach stage.
package crc_pkg;

  localparam int K_SMALL = 1056;
  localparam int K_LARGE = 6144;
  localparam int CRC_LEN = 24;
  localparam logic [CRC_LEN-1:0] CRC_POLY = 24'h864CFB;

  localparam int P_SMALL = K_SMALL - CRC_LEN;
  localparam int P_LARGE = K_LARGE - CRC_LEN;
  localparam int CNT_W   = 13;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    APPEND  = 2'd2
  } state_t;

  // One MSB-first Galois step; x^24 is implicit in the feedback.
  function automatic logic [CRC_LEN-1:0] crc_step(input logic [CRC_LEN-1:0] crc,
                                                  input logic bit_in);
    logic fb;
    fb = crc[CRC_LEN-1] ^ bit_in;
    return {crc[CRC_LEN-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/crc24_lfsr.sv
// Serial CRC24A Galois LFSR: absorbs payload bits MSB first, then shifts the
// remainder out MSB first with zeros filling in from the bottom.
module crc24_lfsr
  import crc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic shift_in_en,
  input  logic bit_in,
  input  logic shift_out_en,
  output logic crc_msb
);

  logic [CRC_LEN-1:0] crc_reg;
  logic [CRC_LEN-1:0] crc_base;

  // clear together with shift_in_en seeds the first bit into a zero register
  assign crc_base = clear ? '0 : crc_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_reg <= '0;
    end else if (shift_in_en) begin
      crc_reg <= crc_step(crc_base, bit_in);
    end else if (shift_out_en) begin
      crc_reg <= {crc_reg[CRC_LEN-2:0], 1'b0};
    end else if (clear) begin
      crc_reg <= '0;
    end
  end

  assign crc_msb = crc_reg[CRC_LEN-1];

endmodule

// File: rtl/crc24_attach.sv
// Serial CRC24A attach: forwards a payload and appends 24 parity bits as one
// contiguous K-bit block, driving the interleaver's CRC_* framing controls.
module crc24_attach
  import crc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic tb_data_in,
  input  logic tb_start,
  input  logic tb_blocksize,
  output logic in_ready,
  output logic data_out,
  output logic out_valid,
  output logic CRC_start,
  output logic CRC_blocksize,
  output logic CRC_end
);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] last_payload;
  logic             accept;
  logic             crc_msb;

  assign in_ready     = (state == IDLE);
  assign accept       = in_ready && tb_start;
  // CRC_blocksize holds the size latched at accept for the whole block
  assign last_payload = CRC_blocksize ? CNT_W'(P_LARGE - 1) : CNT_W'(P_SMALL - 1);

  crc24_lfsr u_lfsr (
    .clk          (clk),
    .reset        (reset),
    .clear        (accept),
    .shift_in_en  (accept || (state == PAYLOAD)),
    .bit_in       (tb_data_in),
    .shift_out_en (state == APPEND),
    .crc_msb      (crc_msb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      counter       <= '0;
      data_out      <= 1'b0;
      out_valid     <= 1'b0;
      CRC_start     <= 1'b0;
      CRC_end       <= 1'b0;
      CRC_blocksize <= 1'b0;
    end else begin
      CRC_start <= 1'b0;
      CRC_end   <= 1'b0;
      case (state)
        IDLE: begin
          if (tb_start) begin
            state         <= PAYLOAD;
            counter       <= CNT_W'(1);
            data_out      <= tb_data_in;
            out_valid     <= 1'b1;
            CRC_start     <= 1'b1;
            CRC_blocksize <= tb_blocksize;
          end else begin
            data_out  <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        PAYLOAD: begin
          data_out  <= tb_data_in;
          out_valid <= 1'b1;
          if (counter == last_payload) begin
            state   <= APPEND;
            counter <= '0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        APPEND: begin
          data_out  <= crc_msb;
          out_valid <= 1'b1;
          // leaving here makes the cycle carrying CRC_end an accept cycle
          if (counter == CNT_W'(CRC_LEN - 1)) begin
            state   <= IDLE;
            counter <= '0;
            CRC_end <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          counter   <= '0;
          data_out  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc24_attach.sv
// Directed bench for crc24_attach: table of whole-block vectors plus
// hand-written back-to-back and mid-block reset sequences.
module tb_crc24_attach;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tb_data_in = 1'b0;
  logic tb_start = 1'b0;
  logic tb_blocksize = 1'b0;
  logic in_ready, data_out, out_valid, CRC_start, CRC_blocksize, CRC_end;

  int n_tests = 0;
  int n_fail  = 0;

  bit pl [0:6143];
  bit ob [0:6143];

  typedef struct {
    bit          bsize;
    int          pat;      // 0 zeros, 1 single one at arg, 2 random seeded by arg
    int          arg;
    bit          has_par;
    logic [23:0] par;
  } vec_t;

  vec_t vecs [5];

  crc24_attach dut (
    .clk           (clk),
    .reset         (reset),
    .tb_data_in    (tb_data_in),
    .tb_start      (tb_start),
    .tb_blocksize  (tb_blocksize),
    .in_ready      (in_ready),
    .data_out      (data_out),
    .out_valid     (out_valid),
    .CRC_start     (CRC_start),
    .CRC_blocksize (CRC_blocksize),
    .CRC_end       (CRC_end)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  function automatic logic [23:0] ref_step(input logic [23:0] c, input bit b);
    logic fb;
    fb = c[23] ^ b;
    return {c[22:0], 1'b0} ^ (fb ? 24'h864CFB : 24'h0);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic fill_payload(input int pat, input int arg, input int p);
    if (pat == 2) void'($urandom(arg));
    for (int i = 0; i < 6144; i++) begin
      if (i >= p)           pl[i] = 1'b0;
      else if (pat == 1)    pl[i] = (i == arg);
      else if (pat == 2)    pl[i] = 1'($urandom_range(0, 1));
      else                  pl[i] = 1'b0;
    end
  endtask

  // Runs one block; also pokes a stray tb_start mid-payload and toggles tb_blocksize.
  task automatic run_block(input int id, input bit bsize, input int pat, input int arg,
                           input bit has_par, input logic [23:0] par_const);
    int k, p, nvalid, nstart, nend, start_c, end_c, bad_data, bad_bs;
    logic [23:0] exp_par, got_par, res;
    k = bsize ? 6144 : 1056;
    p = k - 24;
    fill_payload(pat, arg, p);
    exp_par = 24'h0;
    for (int i = 0; i < p; i++) exp_par = ref_step(exp_par, pl[i]);
    nvalid = 0; nstart = 0; nend = 0; start_c = -1; end_c = -1; bad_data = 0; bad_bs = 0;
    @(negedge clk);
    check($sformatf("v%0d in_ready_idle", id), 32'(in_ready), 32'd1);
    tb_start = 1'b1; tb_blocksize = bsize; tb_data_in = pl[0];
    for (int c = 1; c <= k + 2; c++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
      if (c <= k) ob[c-1] = data_out;
      if (c <= p && data_out !== pl[c-1]) bad_data++;
      if (CRC_start) begin nstart++; start_c = c; end
      if (CRC_end)   begin nend++;   end_c = c;   end
      if (c <= k && CRC_blocksize !== bsize) bad_bs++;
      if (c == 1) check($sformatf("v%0d in_ready_busy", id), 32'(in_ready), 32'd0);
      if (c == k) check($sformatf("v%0d in_ready_at_end", id), 32'(in_ready), 32'd1);
      tb_start     = (c == 100);
      tb_blocksize = ~bsize;
      tb_data_in   = (c < p) ? pl[c] : 1'b1;
    end
    tb_start = 1'b0; tb_blocksize = 1'b0; tb_data_in = 1'b0;
    got_par = 24'h0;
    for (int i = p; i < k; i++) got_par = {got_par[22:0], ob[i]};
    res = 24'h0;
    for (int i = 0; i < k; i++) res = ref_step(res, ob[i]);
    check($sformatf("v%0d valid_count", id), 32'(nvalid), 32'(k));
    check($sformatf("v%0d start_count", id), 32'(nstart), 32'd1);
    check($sformatf("v%0d start_cycle", id), 32'(start_c), 32'd1);
    check($sformatf("v%0d end_count", id), 32'(nend), 32'd1);
    check($sformatf("v%0d end_cycle", id), 32'(end_c), 32'(k));
    check($sformatf("v%0d payload_errors", id), 32'(bad_data), 32'd0);
    check($sformatf("v%0d blocksize_errors", id), 32'(bad_bs), 32'd0);
    check($sformatf("v%0d parity_model", id), 32'(got_par), 32'(exp_par));
    check($sformatf("v%0d residue", id), 32'(res), 32'd0);
    if (has_par) check($sformatf("v%0d parity_const", id), 32'(got_par), 32'(par_const));
  endtask

  initial begin
    int gaps, st1, st2, en1, en2, nst, nen;
    logic [23:0] parA, parB;

    vecs[0] = '{bsize: 1'b0, pat: 0, arg: 0,    has_par: 1'b1, par: 24'h000000};
    vecs[1] = '{bsize: 1'b0, pat: 1, arg: 1031, has_par: 1'b1, par: 24'h864CFB};
    vecs[2] = '{bsize: 1'b0, pat: 1, arg: 1030, has_par: 1'b1, par: 24'h8AD50D};
    vecs[3] = '{bsize: 1'b1, pat: 2, arg: 17,   has_par: 1'b0, par: 24'h0};
    vecs[4] = '{bsize: 1'b0, pat: 2, arg: 99,   has_par: 1'b0, par: 24'h0};

    // reset state, while reset is held
    #3;
    check("reset data_out", 32'(data_out), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset CRC_start", 32'(CRC_start), 32'd0);
    check("reset CRC_end", 32'(CRC_end), 32'd0);
    check("reset CRC_blocksize", 32'(CRC_blocksize), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++)
      run_block(v, vecs[v].bsize, vecs[v].pat, vecs[v].arg, vecs[v].has_par, vecs[v].par);

    // back-to-back: two small blocks, each with a single one at payload bit 1031
    gaps = 0; nst = 0; nen = 0; st1 = -1; st2 = -1; en1 = -1; en2 = -1;
    parA = 24'h0; parB = 24'h0;
    @(negedge clk);
    tb_start = 1'b1; tb_blocksize = 1'b0; tb_data_in = 1'b0;
    for (int c = 1; c <= 2114; c++) begin
      @(negedge clk);
      if (c <= 2112 && !out_valid) gaps++;
      if (c == 2113) check("b2b valid_drops_after", 32'(out_valid), 32'd0);
      if (CRC_start) begin nst++; if (st1 < 0) st1 = c; else st2 = c; end
      if (CRC_end)   begin nen++; if (en1 < 0) en1 = c; else en2 = c; end
      if (c >= 1033 && c <= 1056) parA = {parA[22:0], data_out};
      if (c >= 2089 && c <= 2112) parB = {parB[22:0], data_out};
      if (c == 1056) check("b2b in_ready_on_end", 32'(in_ready), 32'd1);
      tb_start   = (c == 1056);
      tb_data_in = (c == 1031) || (c == 1056 + 1031);
    end
    tb_start = 1'b0; tb_data_in = 1'b0;
    check("b2b valid_gaps", 32'(gaps), 32'd0);
    check("b2b start_count", 32'(nst), 32'd2);
    check("b2b start2_cycle", 32'(st2), 32'd1057);
    check("b2b end_count", 32'(nen), 32'd2);
    check("b2b end1_cycle", 32'(en1), 32'd1056);
    check("b2b end2_cycle", 32'(en2), 32'd2112);
    check("b2b parity_a", 32'(parA), 32'h864CFB);
    check("b2b parity_b", 32'(parB), 32'h864CFB);

    // reset in the middle of a large block
    fill_payload(2, 5, 6120);
    @(negedge clk);
    tb_start = 1'b1; tb_blocksize = 1'b1; tb_data_in = pl[0];
    for (int c = 1; c <= 500; c++) begin
      @(negedge clk);
      tb_start = 1'b0; tb_data_in = pl[c];
    end
    check("midrst valid_before", 32'(out_valid), 32'd1);
    check("midrst blocksize_before", 32'(CRC_blocksize), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst data_out", 32'(data_out), 32'd0);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst CRC_blocksize", 32'(CRC_blocksize), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0; tb_data_in = 1'b0;
    nen = 0; gaps = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (CRC_end) nen++;
      if (out_valid) gaps++;
    end
    check("midrst no_stale_end", 32'(nen), 32'd0);
    check("midrst idle_valid", 32'(gaps), 32'd0);
    run_block(5, 1'b0, 1, 1031, 1'b1, 24'h864CFB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
